// File: rtl/partial_load_unit_if.sv
// rtl/partial_load_unit_if.sv - bus bundle between the load-data stage and its producer/consumer
//
// Purpose: groups the writeback-side load inputs and the aligned result outputs.
// Signals:
//   in_valid       instruction/data/address valid this cycle
//   instruction    instruction in writeback (opcode [6:0], funct3 [14:12])
//   data_from_mem  raw aligned word read from data memory
//   mem_addr       effective load address (only [1:0] matter)
//   data_to_reg    aligned, extended load result
//   out_valid      data_to_reg valid
//   misaligned     address misaligned for the access size (flag only)
// Modports: master drives the inputs and observes the result; slave is the load unit.

interface partial_load_unit_if;
  logic        in_valid;
  logic [31:0] instruction;
  logic [31:0] data_from_mem;
  logic [31:0] mem_addr;
  logic [31:0] data_to_reg;
  logic        out_valid;
  logic        misaligned;

  modport master (
    output in_valid, instruction, data_from_mem, mem_addr,
    input  data_to_reg, out_valid, misaligned
  );

  modport slave (
    input  in_valid, instruction, data_from_mem, mem_addr,
    output data_to_reg, out_valid, misaligned
  );
endinterface

// File: rtl/partial_load_unit.sv
// rtl/partial_load_unit.sv - RISC-V load-data alignment and sign/zero extension stage
//
// Purpose: picks the addressed byte/halfword out of the raw memory word, extends it
// according to funct3, and presents the register-file write value. Non-loads and
// undefined load funct3 codes pass the memory word through untouched.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (clears registered outputs)
//   bus     partial_load_unit_if.slave (see interface file for signal list)
// Parameter:
//   REG_OUT 1: outputs registered, 1-cycle latency; 0: purely combinational

module partial_load_unit #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  partial_load_unit_if.slave  bus
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic        is_load;
  logic [2:0]  funct3;
  logic [1:0]  byte_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] data_to_reg_d;
  logic        misaligned_d;

  // Only the opcode, funct3 and the low address bits steer the result.
  logic unused_bits;
  assign unused_bits = ^{bus.instruction[31:15], bus.instruction[11:7], bus.mem_addr[31:2]};

  always_comb begin
    is_load  = (bus.instruction[6:0] == OPC_LOAD);
    funct3   = bus.instruction[14:12];
    byte_sel = bus.mem_addr[1:0];

    case (byte_sel)
      2'd0:    ld_byte = bus.data_from_mem[7:0];
      2'd1:    ld_byte = bus.data_from_mem[15:8];
      2'd2:    ld_byte = bus.data_from_mem[23:16];
      default: ld_byte = bus.data_from_mem[31:24];
    endcase

    // Any nonzero byte offset selects the upper half, including odd misaligned ones.
    ld_half = (byte_sel == 2'b00) ? bus.data_from_mem[15:0] : bus.data_from_mem[31:16];

    data_to_reg_d = bus.data_from_mem;
    misaligned_d  = 1'b0;

    if (is_load) begin
      case (funct3)
        F3_LB:  data_to_reg_d = {{24{ld_byte[7]}}, ld_byte};
        F3_LBU: data_to_reg_d = {24'b0, ld_byte};
        F3_LH: begin
          data_to_reg_d = {{16{ld_half[15]}}, ld_half};
          misaligned_d  = byte_sel[0];
        end
        F3_LHU: begin
          data_to_reg_d = {16'b0, ld_half};
          misaligned_d  = byte_sel[0];
        end
        F3_LW: begin
          data_to_reg_d = bus.data_from_mem;
          misaligned_d  = (byte_sel != 2'b00);
        end
        default: data_to_reg_d = bus.data_from_mem;
      endcase
    end
  end

  if (REG_OUT) begin : g_reg
    logic [31:0] data_to_reg_q;
    logic        misaligned_q;
    logic        out_valid_q;
    logic        out_valid_d;

    always_comb begin
      out_valid_d = bus.in_valid;
    end

    // Data registers load every cycle; out_valid qualifies them downstream.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_to_reg_q <= 32'b0;
        misaligned_q  <= 1'b0;
        out_valid_q   <= 1'b0;
      end else begin
        data_to_reg_q <= data_to_reg_d;
        misaligned_q  <= misaligned_d;
        out_valid_q   <= out_valid_d;
      end
    end

    assign bus.data_to_reg = data_to_reg_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.out_valid   = out_valid_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;

    assign bus.data_to_reg = data_to_reg_d;
    assign bus.misaligned  = misaligned_d;
    assign bus.out_valid   = bus.in_valid;
  end

endmodule

// File: tb/tb_partial_load_unit.sv
// tb/tb_partial_load_unit.sv - scoreboard bench for partial_load_unit (REG_OUT=1)

module tb_partial_load_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  partial_load_unit_if bus ();

  partial_load_unit #(.REG_OUT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [2:0] f3, input logic [6:0] opc,
                                         input logic [21:0] junk);
    return {junk[16:0], f3, junk[21:17], opc};
  endfunction

  // Reference: byte via shift by 8*offset, halfword via shift by 16 unless offset 0.
  function automatic exp_t model(input logic v, input logic [31:0] ins,
                                 input logic [31:0] data, input logic [31:0] addr);
    exp_t        e;
    logic [1:0]  a;
    logic [7:0]  by;
    logic [15:0] hw;
    logic [31:0] sh;
    a  = addr[1:0];
    sh = data >> (8 * int'(a));
    by = sh[7:0];
    sh = (a == 2'd0) ? data : (data >> 16);
    hw = sh[15:0];
    e.valid = v;
    e.mis   = 1'b0;
    e.data  = data;
    if (ins[6:0] == 7'b0000011) begin
      case (ins[14:12])
        3'b000: e.data = {{24{by[7]}}, by};
        3'b100: e.data = {24'h0, by};
        3'b001: begin e.data = {{16{hw[15]}}, hw}; e.mis = a[0]; end
        3'b101: begin e.data = {16'h0, hw};        e.mis = a[0]; end
        3'b010: e.mis = (a != 2'd0);
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] data, input logic [31:0] addr);
    bus.in_valid      = v;
    bus.instruction   = ins;
    bus.data_from_mem = data;
    bus.mem_addr      = addr;
    sb.push_back(model(v, ins, data, addr));
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    chk({tag, ".sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".data"},  bus.data_to_reg,       e.data);
      chk({tag, ".valid"}, 32'(bus.out_valid),    32'(e.valid));
      chk({tag, ".mis"},   32'(bus.misaligned),   32'(e.mis));
    end
  endtask

  localparam logic [6:0] LD = 7'b0000011;

  initial begin
    rst_n             = 1'b0;
    bus.in_valid      = 1'b1;
    bus.instruction   = mk_ins(3'b000, LD, 22'h0);
    bus.data_from_mem = 32'hDEADBEEF;
    bus.mem_addr      = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.data",  bus.data_to_reg,    32'h0);
    chk("rst.valid", 32'(bus.out_valid), 32'h0);
    chk("rst.mis",   32'(bus.misaligned), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    drive(1'b1, mk_ins(3'b000, LD, 22'h0), 32'h12345678, 32'h1);   tick("lb_a1");
    drive(1'b1, mk_ins(3'b000, LD, 22'h0), 32'h89ABCDEF, 32'h3);   tick("lb_a3");
    drive(1'b1, mk_ins(3'b001, LD, 22'h0), 32'h89ABCDEF, 32'h0);   tick("lh_a0");
    drive(1'b1, mk_ins(3'b101, LD, 22'h0), 32'h89ABCDEF, 32'h1);   tick("lhu_a1");
    drive(1'b1, mk_ins(3'b010, LD, 22'h0), 32'h12345678, 32'h3);   tick("lw_a3");
    drive(1'b1, 32'h0,                     32'h87654321, 32'h2);   tick("nonld");
    drive(1'b1, mk_ins(3'b100, LD, 22'h0), 32'h89ABCDEF, 32'h2);   tick("lbu_a2");
    drive(1'b1, mk_ins(3'b011, LD, 22'h0), 32'h89ABCDEF, 32'h1);   tick("f3_011");
    drive(1'b0, mk_ins(3'b001, LD, 22'h0), 32'h0000F0F0, 32'h2);   tick("lh_a2_nv");
    drive(1'b1, mk_ins(3'b001, LD, 22'h3FFFFF), 32'h7FFF8000, 32'hFFFFFFF0); tick("lh_hiaddr");

    // Back-to-back LB/LHU with in_valid toggling
    for (int i = 0; i < 24; i++) begin
      drive(i[0], mk_ins((i % 2 == 0) ? 3'b000 : 3'b101, LD, 22'($urandom)),
            $urandom, $urandom);
      tick("b2b");
    end

    // Random mix of all funct3 codes and opcodes
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom), mk_ins(3'($urandom), (i % 4 == 0) ? 7'($urandom) : LD,
            22'($urandom)), $urandom, $urandom);
      tick("rnd");
    end

    // Reset mid-operation: outputs clear immediately, then follow inputs after release
    drive(1'b1, mk_ins(3'b000, LD, 22'h0), 32'h000000F0, 32'h0);
    tick("pre_rst");
    drive(1'b1, mk_ins(3'b100, LD, 22'h0), 32'hA5C3E100, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst.data",  bus.data_to_reg,    32'h0);
    chk("mrst.valid", 32'(bus.out_valid), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    chk("mrst.hold", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(bus.in_valid, bus.instruction, bus.data_from_mem, bus.mem_addr));
    tick("rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
